deck_shuffler: RTL and testbench
================================

Name: deck_shuffler

Overview:
- Sits between the ordered-deck generator and the dealing/setup stage.
- Captures a 52-card ordered deck and performs an in-place Fisher-Yates shuffle driven by a seeded 16-bit LFSR.
- Streams the shuffled deck out one card per accepted transfer to the dealer.
- Card encoding: [6:3] rank 1..13, [2:1] suit (HEARTS, SPADES, DIAMONDS, CLUBS from parameters.v), [0] face-up flag.

Parameters:
- CARD_W, 7, bits per card.
- DECK_SIZE, 52, cards per deck; index width 6.
- LFSR_W, 16, LFSR width.
- DEFAULT_SEED, 16'hACE1, seed substituted when seed input is 0.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse; captures deck_in and seed. Honoured only in IDLE or DONE.
- seed  input  16  LFSR seed.
- deck_in  input  364  flat ordered deck; card k = deck_in[7k+6:7k].
- busy  output  1  high in every state except IDLE and DONE.
- card_out  output  7  current shuffled card.
- card_idx  output  6  position of card_out, 0..51.
- card_valid  output  1  card_out is valid.
- card_ready  input  1  downstream accepts the card.
- done  output  1  high once card 51 has been accepted; held until the next start.
- deck_err  output  1  input deck rejected (DECK_CHECK_EN only; tied 0 otherwise).

Behaviour:
- Reset (synchronous, active-high) returns the block to IDLE:
  - busy = 0, card_valid = 0, done = 0, deck_err = 0, card_out = 0, card_idx = 0.
  - LFSR = DEFAULT_SEED. Internal deck array is not cleared.
- Reset mid-operation aborts immediately to IDLE; any partial output stream is discarded.
- States: IDLE, LOAD, DRAW, SWAP, EMIT, DONE, plus CHECK with the optional feature.
- IDLE/DONE + start:
  - Latch deck_in into mem[0..51].
  - LFSR = (seed == 0) ? DEFAULT_SEED : seed.
  - i = 51; clear done and deck_err; go to LOAD.
- start in any other state is ignored.
- LOAD: one cycle, then go to DRAW (or CHECK).
- LFSR: Galois, right-shifting, taps 16'hB400. It advances exactly once per DRAW cycle and holds in all other states.
- DRAW:
  - cand = lfsr[5:0] & mask(i), where mask(i) = 2^ceil(log2(i+1)) - 1. Examples: i=51 gives 63, i=31 gives 31, i=1 gives 1.
  - If cand <= i: j = cand, go to SWAP.
  - Otherwise stay in DRAW (rejection sampling; no modulo allowed).
- SWAP:
  - One cycle: mem[i] <= mem[j] and mem[j] <= mem[i] in the same edge. j == i is legal and leaves mem unchanged.
  - If i == 1, set k = 0 and go to EMIT; otherwise i <= i - 1 and go to DRAW.
- EMIT:
  - card_valid = 1, card_out = mem[k], card_idx = k.
  - card_out and card_idx stay stable while card_valid is high and card_ready is low.
  - On card_valid & card_ready: k <= k + 1. When k == 51 is accepted: card_valid <= 0 and go to DONE.
  - At most one card is transferred per cycle; card_ready is ignored outside EMIT.
- DONE: done = 1, busy = 0.
- Latency:
  - Start to first card_valid = 2 + 51 SWAP cycles + total DRAW cycles. Each i costs at least one DRAW cycle, so the minimum is 104 cycles.
  - Output phase: 52 cycles with card_ready held high.
- Determinism: the same seed and deck_in always produce the same output order.
- Invariant: the output is a permutation of the input; every card is emitted exactly once.

Optional Feature:
- Macro: DECK_CHECK_EN.
- When defined:
  - A CHECK state is inserted after LOAD. It scans mem[0..51], one card per cycle, for 52 cycles.
  - A 52-bit seen bitmap is indexed by (rank-1)*4 + suit.
  - A card is in error if its rank is 0 or greater than 13, its face bit is 1, or its bitmap bit is already set.
  - On the first error: deck_err <= 1, go to DONE with done = 1 and no cards emitted.
  - If all 52 cards pass, go to DRAW. This adds 52 cycles to the latency.
- When undefined: no CHECK state, and deck_err is tied to 0.

Test Plan:
- Reset, then start with seed=16'h0001 and an ordered deck (card k = {rank k/4+1, suit k%4, 0}), card_ready held high:
  - Exactly 52 valid transfers with card_idx 0..51.
  - The output multiset equals the input.
  - done rises the cycle after idx 51 is accepted.
  - Output matches the reference-model sequence.
- seed=0 vs seed=16'hACE1, same deck -> identical output streams. seed=16'h1234 -> a different stream.
- card_ready toggled at random (about 30% high) -> card_out and card_idx are stable while stalled; no card is duplicated or dropped.
- Assert rst during DRAW at i=30, and again during EMIT at k=10:
  - Next cycle busy = 0, card_valid = 0, done = 0.
  - A following start completes normally.
- start pulsed during SWAP and during EMIT -> ignored; the stream is unchanged versus a run without the pulse.
- DECK_CHECK_EN:
  - Card 5 duplicated into card 20 -> deck_err = 1, done = 1, zero card_valid cycles.
  - Card with rank 14 -> same response.
  - Clean deck -> deck_err = 0, and the first card_valid arrives 52 cycles later than in the non-check build.

Source files
------------

// File: rtl/deck_shuffler_if.sv
// Card-stream bus between the deck shuffler (slave) and its controller/dealer (master).
interface deck_shuffler_if #(
    parameter int CARD_W    = 7,
    parameter int DECK_SIZE = 52,
    parameter int LFSR_W    = 16,
    parameter int IDX_W     = 6
);
    logic                        start;
    logic [LFSR_W-1:0]           seed;
    logic [CARD_W*DECK_SIZE-1:0] deck_in;
    logic                        busy;
    logic [CARD_W-1:0]           card_out;
    logic [IDX_W-1:0]            card_idx;
    logic                        card_valid;
    logic                        card_ready;
    logic                        done;
    logic                        deck_err;

    // A card moves on a rising edge where card_valid && card_ready; once raised, card_valid
    // stays high with card_out/card_idx frozen until that edge, and card_ready never gates card_valid.
    modport master (
        output start, seed, deck_in, card_ready,
        input  busy, card_out, card_idx, card_valid, done, deck_err
    );

    modport slave (
        input  start, seed, deck_in, card_ready,
        output busy, card_out, card_idx, card_valid, done, deck_err
    );
endinterface

// File: rtl/deck_shuffler.sv
// In-place Fisher-Yates shuffle of a 52-card deck driven by a Galois LFSR, streamed out one card per transfer.
// Optional input-deck validation (CHECK state, deck_err) is enabled with `define DECK_CHECK_EN.
module deck_shuffler #(
    parameter int                CARD_W       = 7,
    parameter int                DECK_SIZE    = 52,
    parameter int                LFSR_W       = 16,
    parameter logic [LFSR_W-1:0] DEFAULT_SEED = 16'hACE1
) (
    input  logic           clk,
    input  logic           rst,
    deck_shuffler_if.slave bus,
    output logic [2:0]     dbg_state
);
    localparam int                IDX_W = $clog2(DECK_SIZE);
    localparam logic [IDX_W-1:0]  LAST  = IDX_W'(DECK_SIZE - 1);
    localparam logic [LFSR_W-1:0] TAPS  = LFSR_W'(16'hB400);

    typedef enum logic [2:0] {
        IDLE, LOAD, DRAW, SWAP, EMIT, DONE
`ifdef DECK_CHECK_EN
        , CHECK
`endif
    } state_t;

    state_t            state, state_nxt;
    logic [CARD_W-1:0] mem [DECK_SIZE];
    logic [LFSR_W-1:0] lfsr, lfsr_nxt;
    logic [IDX_W-1:0]  i, j, k;
    logic [IDX_W-1:0]  cand;
    logic              draw_ok;

    // Smallest all-ones value covering n, so candidates are uniform over [0, mask] before rejection.
    function automatic logic [IDX_W-1:0] draw_mask(input logic [IDX_W-1:0] n);
        draw_mask = '0;
        for (int b = 0; b < IDX_W; b++)
            if ((n >> b) != '0) draw_mask[b] = 1'b1;
    endfunction

    assign cand      = lfsr[IDX_W-1:0] & draw_mask(i);
    assign draw_ok   = (cand <= i);
    assign lfsr_nxt  = lfsr[0] ? ((lfsr >> 1) ^ TAPS) : (lfsr >> 1);
    assign dbg_state = state;

`ifdef DECK_CHECK_EN
    logic [DECK_SIZE-1:0] seen;
    logic [CARD_W-1:0]    chk_card;
    logic [3:0]           chk_rank;
    logic [IDX_W-1:0]     chk_pos;
    logic                 chk_err;
    logic                 deck_err_q;

    assign chk_card     = mem[k];
    assign chk_rank     = chk_card[6:3];
    assign chk_pos      = IDX_W'({chk_rank - 4'd1, chk_card[2:1]});
    assign chk_err      = (chk_rank == 4'd0) || (chk_rank > 4'd13) || chk_card[0] || seen[chk_pos];
    assign bus.deck_err = deck_err_q;
`else
    assign bus.deck_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Datapath; the deck array is deliberately left untouched by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr       <= DEFAULT_SEED;
            i          <= '0;
            j          <= '0;
            k          <= '0;
`ifdef DECK_CHECK_EN
            deck_err_q <= 1'b0;
            seen       <= '0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        for (int n = 0; n < DECK_SIZE; n++)
                            mem[n] <= bus.deck_in[n*CARD_W +: CARD_W];
                        lfsr <= (bus.seed == '0) ? DEFAULT_SEED : bus.seed;
                        i    <= LAST;
                        k    <= '0;
`ifdef DECK_CHECK_EN
                        deck_err_q <= 1'b0;
                        seen       <= '0;
`endif
                    end
                end
                DRAW: begin
                    lfsr <= lfsr_nxt;
                    if (draw_ok) j <= cand;
                end
                SWAP: begin
                    mem[i] <= mem[j];
                    mem[j] <= mem[i];
                    if (i == IDX_W'(1)) k <= '0;
                    else                i <= i - IDX_W'(1);
                end
                EMIT: begin
                    if (bus.card_ready && (k != LAST)) k <= k + IDX_W'(1);
                end
`ifdef DECK_CHECK_EN
                CHECK: begin
                    if (chk_err) begin
                        deck_err_q <= 1'b1;
                    end else begin
                        seen[chk_pos] <= 1'b1;
                        k <= (k == LAST) ? '0 : k + IDX_W'(1);
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt      = state;
        bus.busy       = 1'b1;
        bus.card_valid = 1'b0;
        bus.card_out   = '0;
        bus.card_idx   = '0;
        bus.done       = 1'b0;
        case (state)
            IDLE: begin
                bus.busy = 1'b0;
                if (bus.start) state_nxt = LOAD;
            end
            LOAD: begin
`ifdef DECK_CHECK_EN
                state_nxt = CHECK;
`else
                state_nxt = DRAW;
`endif
            end
`ifdef DECK_CHECK_EN
            CHECK: begin
                if (chk_err)          state_nxt = DONE;
                else if (k == LAST)   state_nxt = DRAW;
            end
`endif
            DRAW: begin
                if (draw_ok) state_nxt = SWAP;
            end
            SWAP: begin
                state_nxt = (i == IDX_W'(1)) ? EMIT : DRAW;
            end
            EMIT: begin
                bus.card_valid = 1'b1;
                bus.card_out   = mem[k];
                bus.card_idx   = k;
                if (bus.card_ready && (k == LAST)) state_nxt = DONE;
            end
            DONE: begin
                bus.busy = 1'b0;
                bus.done = 1'b1;
                if (bus.start) state_nxt = LOAD;
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_deck_shuffler.sv
// Directed bench for deck_shuffler: reference Fisher-Yates model feeds an expected-card queue.
module tb_deck_shuffler;
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_DRAW = 3'd2;
    localparam logic [2:0] ST_SWAP = 3'd3;
`ifdef DECK_CHECK_EN
    localparam int CHK_EXTRA = 52;
`else
    localparam int CHK_EXTRA = 0;
`endif

    logic       clk;
    logic       rst;
    logic [2:0] dbg_state;

    deck_shuffler_if #(.CARD_W(7), .DECK_SIZE(52), .LFSR_W(16), .IDX_W(6)) bus ();

    deck_shuffler #(.CARD_W(7), .DECK_SIZE(52), .LFSR_W(16), .DEFAULT_SEED(16'hACE1)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave),
        .dbg_state (dbg_state)
    );

    int         n_cmp = 0;
    int         n_err = 0;
    logic [6:0] exp_q[$];
    logic [6:0] deck_arr[52];
    logic [6:0] got[52];
    logic [6:0] ref0[52];
    int         model_draws;

    // ---------------- clock / watchdog ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // ---------------- checker ----------------
    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        logic [15:0] r;
        r = l >> 1;
        if (l[0]) r = r ^ 16'hB400;
        return r;
    endfunction

    task automatic model_run(input logic [15:0] s);
        logic [15:0] l;
        logic [6:0]  d[52];
        logic [6:0]  t;
        int          m, c;
        l = (s == 16'h0) ? 16'hACE1 : s;
        model_draws = 0;
        for (int n = 0; n < 52; n++) d[n] = deck_arr[n];
        for (int ii = 51; ii >= 1; ii--) begin
            m = 1;
            while (m < ii) m = m * 2 + 1;
            c = ii + 1;
            while (c > ii) begin
                c = int'(l[5:0]) & m;
                l = lfsr_step(l);
                model_draws++;
            end
            t = d[ii]; d[ii] = d[c]; d[c] = t;
        end
        exp_q.delete();
        for (int n = 0; n < 52; n++) exp_q.push_back(d[n]);
    endtask

    // ---------------- drivers ----------------
    task automatic set_deck_ordered();
        for (int n = 0; n < 52; n++) deck_arr[n] = {4'(n / 4 + 1), 2'(n % 4), 1'b0};
    endtask

    task automatic pack_deck();
        for (int n = 0; n < 52; n++) bus.deck_in[n*7 +: 7] = deck_arr[n];
    endtask

    task automatic do_start(input logic [15:0] s);
        pack_deck();
        @(negedge clk);
        bus.seed  = s;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Runs one shuffle, checking every accepted card against the model; abort_k >= 0 resets mid-EMIT.
    task automatic run_stream(input string tag, input logic [15:0] s, input int ready_pct,
                              input bit inject, input int abort_k);
        int         cyc, n, first_valid, bad;
        int         cnt[128];
        bit         r, stalled, did_swap, did_emit;
        logic [6:0] held_card, e;
        logic [5:0] held_idx;
        model_run(s);
        do_start(s);
        cyc = 1; n = 0; first_valid = -1;
        stalled = 1'b0; did_swap = 1'b0; did_emit = 1'b0;
        held_card = '0; held_idx = '0;
        while (n < 52 && cyc < 3000) begin
            r = ($urandom_range(0, 99) < ready_pct);
            bus.card_ready = r;
            bus.start = 1'b0;
            if (inject && !did_swap && dbg_state == ST_SWAP) begin
                bus.start = 1'b1; bus.seed = 16'h5555; did_swap = 1'b1;
            end
            if (inject && !did_emit && bus.card_valid && n == 5) begin
                bus.start = 1'b1; bus.seed = 16'h5555; did_emit = 1'b1;
            end
            if (bus.card_valid && first_valid < 0) first_valid = cyc;
            if (stalled) begin
                check_val({tag, "_stall_valid"}, bus.card_valid, 1);
                check_val({tag, "_stall_card"}, bus.card_out, held_card);
                check_val({tag, "_stall_idx"}, bus.card_idx, held_idx);
            end
            if (abort_k >= 0 && bus.card_valid && int'(bus.card_idx) == abort_k) begin
                rst = 1'b1;
                bus.card_ready = 1'b0;
                @(negedge clk);
                check_val({tag, "_rst_busy"}, bus.busy, 0);
                check_val({tag, "_rst_valid"}, bus.card_valid, 0);
                check_val({tag, "_rst_done"}, bus.done, 0);
                rst = 1'b0;
                exp_q.delete();
                return;
            end
            if (bus.card_valid && r) begin
                e = exp_q.pop_front();
                check_val({tag, "_card"}, bus.card_out, e);
                check_val({tag, "_idx"}, bus.card_idx, n);
                if (n == 51) check_val({tag, "_done_early"}, bus.done, 0);
                got[n] = bus.card_out;
                n++;
            end
            stalled   = bus.card_valid && !r;
            held_card = bus.card_out;
            held_idx  = bus.card_idx;
            @(negedge clk);
            cyc++;
        end
        bus.start = 1'b0;
        bus.card_ready = 1'b0;
        check_val({tag, "_count"}, n, 52);
        check_val({tag, "_done"}, bus.done, 1);
        check_val({tag, "_valid_after"}, bus.card_valid, 0);
        check_val({tag, "_busy_after"}, bus.busy, 0);
        check_val({tag, "_deck_err"}, bus.deck_err, 0);
        check_val({tag, "_latency"}, first_valid, 53 + model_draws + CHK_EXTRA);
        for (int v = 0; v < 128; v++) cnt[v] = 0;
        for (int v = 0; v < 52; v++) cnt[deck_arr[v]]++;
        for (int v = 0; v < n; v++) cnt[got[v]]--;
        bad = 0;
        for (int v = 0; v < 128; v++) if (cnt[v] != 0) bad++;
        check_val({tag, "_perm"}, bad, 0);
    endtask

    task automatic abort_in_draw(input logic [15:0] s);
        int swaps, cyc;
        bus.card_ready = 1'b1;
        do_start(s);
        swaps = 0; cyc = 0;
        while (swaps < 21 && cyc < 3000) begin
            if (dbg_state == ST_SWAP) swaps++;
            @(negedge clk);
            cyc++;
        end
        check_val("draw30_state", dbg_state, ST_DRAW);
        rst = 1'b1;
        @(negedge clk);
        check_val("draw30_rst_busy", bus.busy, 0);
        check_val("draw30_rst_valid", bus.card_valid, 0);
        check_val("draw30_rst_done", bus.done, 0);
        check_val("draw30_rst_state", dbg_state, ST_IDLE);
        rst = 1'b0;
    endtask

`ifdef DECK_CHECK_EN
    task automatic run_bad(input string tag);
        int cyc, vcnt;
        bus.card_ready = 1'b1;
        do_start(16'h0001);
        cyc = 1; vcnt = 0;
        while (!bus.done && cyc < 500) begin
            if (bus.card_valid) vcnt++;
            @(negedge clk);
            cyc++;
        end
        check_val({tag, "_done"}, bus.done, 1);
        check_val({tag, "_deck_err"}, bus.deck_err, 1);
        check_val({tag, "_valid_cycles"}, vcnt, 0);
        check_val({tag, "_busy"}, bus.busy, 0);
        bus.card_ready = 1'b0;
    endtask
`endif

    // ---------------- main sequence ----------------
    initial begin
        bit same, diff;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.seed = '0;
        bus.card_ready = 1'b0;
        set_deck_ordered();
        pack_deck();
        repeat (3) @(negedge clk);
        check_val("rst_busy", bus.busy, 0);
        check_val("rst_valid", bus.card_valid, 0);
        check_val("rst_done", bus.done, 0);
        check_val("rst_deck_err", bus.deck_err, 0);
        check_val("rst_card_out", bus.card_out, 0);
        check_val("rst_card_idx", bus.card_idx, 0);
        check_val("rst_state", dbg_state, ST_IDLE);
        rst = 1'b0;
        @(negedge clk);

        run_stream("seed0001", 16'h0001, 100, 1'b0, -1);

        run_stream("seed0000", 16'h0000, 100, 1'b0, -1);
        for (int n = 0; n < 52; n++) ref0[n] = got[n];
        run_stream("seedace1", 16'hACE1, 100, 1'b0, -1);
        same = 1'b1;
        for (int n = 0; n < 52; n++) if (got[n] !== ref0[n]) same = 1'b0;
        check_val("seed0_vs_ace1_same", same, 1);
        run_stream("seed1234", 16'h1234, 100, 1'b0, -1);
        diff = 1'b0;
        for (int n = 0; n < 52; n++) if (got[n] !== ref0[n]) diff = 1'b1;
        check_val("seed1234_differs", diff, 1);

        run_stream("stall30", 16'h7E57, 30, 1'b0, -1);
        run_stream("inject", 16'h0001, 100, 1'b1, -1);

        abort_in_draw(16'h0001);
        run_stream("after_draw_rst", 16'h2222, 100, 1'b0, -1);
        run_stream("emit10", 16'h0001, 100, 1'b0, 10);
        run_stream("after_emit_rst", 16'h0BAD, 60, 1'b0, -1);

`ifdef DECK_CHECK_EN
        deck_arr[20] = deck_arr[5];
        run_bad("dup_card");
        set_deck_ordered();
        deck_arr[7] = {4'd14, 2'd1, 1'b0};
        run_bad("rank14");
        set_deck_ordered();
        run_stream("clean_check", 16'h0001, 100, 1'b0, -1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
